// File: rtl/myproject_sdiv_20s_9ns_11s_seq_if.sv
// Operand/result handshake bundle for myproject_sdiv_20s_9ns_11s_seq.
// The master drives operands and out_ready; the slave (the divider) drives results.
interface myproject_sdiv_20s_9ns_11s_seq_if #(
  parameter int unsigned din0_WIDTH = 20,
  parameter int unsigned din1_WIDTH = 9,
  parameter int unsigned dout_WIDTH = 11
);
  logic                  in_valid;
  logic                  in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] quo;
  logic [din1_WIDTH:0]   rem;
  logic                  ovf;
  logic                  dz;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, quo, rem, ovf, dz
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, quo, rem, ovf, dz
  );
endinterface

// File: rtl/myproject_sdiv_20s_9ns_11s_seq.sv
// Sequential restoring divider: signed dividend / unsigned divisor, one quotient bit per clock.
// Define MYPROJECT_SDIV_SAT_EN to saturate quo on overflow; otherwise quo wraps.
module myproject_sdiv_20s_9ns_11s_seq #(
  parameter int unsigned ID         = 1,
  parameter int unsigned din0_WIDTH = 20,
  parameter int unsigned din1_WIDTH = 9,
  parameter int unsigned dout_WIDTH = 11
) (
  input logic ap_clk,
  input logic ap_rst_n,
  myproject_sdiv_20s_9ns_11s_seq_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(din0_WIDTH);
  localparam int unsigned QW   = din0_WIDTH + 1;
  localparam int unsigned RW   = din1_WIDTH + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CntW-1:0]       CntLast = CntW'(din0_WIDTH - 1);
  localparam logic [dout_WIDTH-1:0] QuoMax  = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] QuoMin  = {1'b1, {(dout_WIDTH-1){1'b0}}};
  localparam logic signed [QW-1:0]  FullMax = {{(QW-dout_WIDTH){1'b0}}, QuoMax};
  localparam logic signed [QW-1:0]  FullMin = {{(QW-dout_WIDTH){1'b1}}, QuoMin};

  // ID only tags the instance.
  logic unused_id;
  assign unused_id = ^ID;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic [din0_WIDTH-1:0] mag_q, mag_d;
  logic [din1_WIDTH-1:0] div_q, div_d;
  logic [din1_WIDTH-1:0] part_q, part_d;
  logic [din0_WIDTH-1:0] qmag_q, qmag_d;
  logic [dout_WIDTH-1:0] quo_q, quo_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic                  ovf_q, ovf_d;
  logic                  dz_q, dz_d;

  logic [RW-1:0]         shift_w;
  logic [RW-1:0]         diff_w;
  logic                  ge_w;
  logic [din1_WIDTH-1:0] part_nxt;
  logic [din0_WIDTH-1:0] qmag_nxt;
  logic signed [QW-1:0]  qfull;
  logic [RW-1:0]         rem_full;
  logic                  q_ovf;
  logic [dout_WIDTH-1:0] quo_res;

  // One restoring step; the partial remainder stays below the divisor, so it fits din1_WIDTH.
  always_comb begin
    shift_w  = {part_q, mag_q[din0_WIDTH-1]};
    diff_w   = shift_w - {1'b0, div_q};
    ge_w     = shift_w >= {1'b0, div_q};
    part_nxt = ge_w ? diff_w[din1_WIDTH-1:0] : shift_w[din1_WIDTH-1:0];
    qmag_nxt = {qmag_q[din0_WIDTH-2:0], ge_w};
    qfull    = neg_q ? (QW'(0) - {1'b0, qmag_nxt}) : {1'b0, qmag_nxt};
    rem_full = neg_q ? (RW'(0) - {1'b0, part_nxt}) : {1'b0, part_nxt};
    q_ovf    = (qfull > FullMax) || (qfull < FullMin);
`ifdef MYPROJECT_SDIV_SAT_EN
    quo_res  = q_ovf ? (neg_q ? QuoMin : QuoMax) : qfull[dout_WIDTH-1:0];
`else
    quo_res  = qfull[dout_WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    div_d   = div_q;
    part_d  = part_q;
    qmag_d  = qmag_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          neg_d  = bus_io.din0[din0_WIDTH-1];
          mag_d  = bus_io.din0[din0_WIDTH-1] ? (~bus_io.din0 + 1'b1) : bus_io.din0;
          div_d  = bus_io.din1;
          part_d = '0;
          qmag_d = '0;
          cnt_d  = '0;
          if (bus_io.din1 == '0) begin
            state_d = StDone;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            rem_d   = '0;
            quo_d   = bus_io.din0[din0_WIDTH-1] ? QuoMin : QuoMax;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        mag_d  = mag_q << 1;
        part_d = part_nxt;
        qmag_d = qmag_nxt;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDone;
          quo_d   = quo_res;
          rem_d   = rem_full;
          ovf_d   = q_ovf;
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (bus_io.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      div_q   <= '0;
      part_q  <= '0;
      qmag_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      div_q   <= div_d;
      part_q  <= part_d;
      qmag_q  <= qmag_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.quo       = quo_q;
  assign bus_io.rem       = rem_q;
  assign bus_io.ovf       = ovf_q;
  assign bus_io.dz        = dz_q;

endmodule
